// File: rtl/shift_unit_seq.sv
// Multi-cycle 32-bit shifter (SLL/SRL/SRA/ROL) that moves at most STEP bit positions per cycle.
// Valid/ready handshakes on both sides; a new request is accepted only from IDLE.
module shift_unit_seq #(
    parameter int XLEN = 32,
    parameter int STEP = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] din,
    input  logic [4:0]      shamt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] dout,
    output logic            busy
);

    // state | meaning
    // IDLE  | waiting for a request, in_ready high
    // SHIFT | shifting the latched operand by up to STEP bits per cycle
    // DONE  | result held in dout until the consumer takes it
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_ROL = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [4:0]        rem_q, rem_d;
    logic [1:0]        op_q, op_d;
    logic              sign_q, sign_d;
    logic [XLEN-1:0]   dout_q, dout_d;
    logic              out_valid_q, out_valid_d;

    logic [5:0]        step;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   fill_mask;

    // Step is clamped to the remaining amount, so rem_q never underflows.
    assign step      = ({1'b0, rem_q} < 6'(STEP)) ? {1'b0, rem_q} : 6'(STEP);
    assign fill_mask = ~({XLEN{1'b1}} >> step);

    always_comb begin
        shifted = data_q;
        case (op_q)
            OP_SLL:  shifted = data_q << step;
            OP_SRL:  shifted = data_q >> step;
            OP_SRA:  shifted = (data_q >> step) | (sign_q ? fill_mask : '0);
            OP_ROL:  shifted = (data_q << step) | (data_q >> (XLEN - 32'(step)));
            default: shifted = data_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        rem_d       = rem_q;
        op_d        = op_q;
        sign_d      = sign_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d = din;
                    rem_d  = shamt;
                    op_d   = op;
                    sign_d = din[XLEN-1];
                    if (shamt == 5'd0) begin
                        dout_d  = din;
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                data_d = shifted;
                rem_d  = rem_q - step[4:0];
                if ({1'b0, rem_q} == step) begin
                    dout_d  = shifted;
                    state_d = DONE;
                end
            end
            DONE: begin
                // out_valid rises one cycle after entering DONE and drops after the handshake.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            rem_q       <= '0;
            op_q        <= '0;
            sign_q      <= 1'b0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            rem_q       <= rem_d;
            op_q        <= op_d;
            sign_q      <= sign_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign dout      = dout_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq: directed vector table, backpressure, reset abort
// and a randomized stream checked against an arithmetic reference model.
module tb_shift_unit_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] din = '0;
    logic [4:0]  shamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] dout;
    logic        busy;

    int checks = 0;
    int failures = 0;

    shift_unit_seq #(.XLEN(32), .STEP(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .din(din), .shamt(shamt), .out_valid(out_valid),
        .out_ready(out_ready), .dout(dout), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] din;
        logic [4:0]  shamt;
        logic [31:0] exp_dout;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d, input int sh);
        case (o)
            2'b00:   return d << sh;
            2'b01:   return d >> sh;
            2'b11:   return 32'($signed(d) >>> sh);
            default: return (sh == 0) ? d : ((d << sh) | (d >> (32 - sh)));
        endcase
    endfunction

    function automatic int ref_lat(input int sh);
        return 1 + (sh + 7) / 8;
    endfunction

    // Issues one request from IDLE and waits for out_valid; leaves out_ready low.
    task automatic do_req(input logic [1:0] o, input logic [31:0] d, input logic [4:0] sh,
                          output logic [31:0] res, output int lat);
        chk("pre_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = o; din = d; shamt = sh;
        @(posedge clk); #1;
        in_valid = 1'b0;
        din = $urandom; op = 2'($urandom); shamt = 5'($urandom);
        lat = 0;
        do begin
            if (lat > 0 || !out_valid) begin
                @(posedge clk); #1;
                lat++;
            end
        end while (!out_valid && lat < 20);
        res = dout;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] res;
        int lat;

        vecs.push_back('{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 5});
        vecs.push_back('{2'b11, 32'h8000_0000, 5'd4,  32'hF800_0000, 2});
        vecs.push_back('{2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, 2});
        vecs.push_back('{2'b11, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 5});
        vecs.push_back('{2'b10, 32'h8000_0001, 5'd1,  32'h0000_0003, 2});
        vecs.push_back('{2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1});
        vecs.push_back('{2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1});
        vecs.push_back('{2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1});
        vecs.push_back('{2'b01, 32'hF000_0000, 5'd8,  32'h00F0_0000, 2});
        vecs.push_back('{2'b10, 32'h1234_5678, 5'd16, 32'h5678_1234, 3});
        vecs.push_back('{2'b11, 32'h8000_0000, 5'd9,  32'hFFC0_0000, 3});
        vecs.push_back('{2'b10, 32'h8765_4321, 5'd31, 32'hC3B2_A190, 5});

        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            do_req(vecs[i].op, vecs[i].din, vecs[i].shamt, res, lat);
            chk($sformatf("vec%0d_dout", i), res, vecs[i].exp_dout);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_model", i), res, ref_shift(vecs[i].op, vecs[i].din, int'(vecs[i].shamt)));
            release_result();
            chk($sformatf("vec%0d_idle", i), 32'(in_ready), 32'd1);
        end

        // Backpressure: result must stay put and a stray in_valid must be ignored.
        do_req(2'b00, 32'h0000_000F, 5'd8, res, lat);
        chk("bp_first", res, 32'h0000_0F00);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                in_valid = 1'b1; din = 32'hAAAA_5555; shamt = 5'd3; op = 2'b01;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("bp_dout", dout, 32'h0000_0F00);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        release_result();
        chk("bp_in_ready_after", 32'(in_ready), 32'd1);
        chk("bp_out_valid_after", 32'(out_valid), 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("bp_no_ghost", 32'(out_valid), 32'd0);
        end

        // Reset during the second SHIFT cycle.
        in_valid = 1'b1; op = 2'b00; din = 32'h0000_0001; shamt = 5'd31;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_dout", dout, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            chk("mid_post_in_ready", 32'(in_ready), 32'd1);
            chk("mid_post_out_valid", 32'(out_valid), 32'd0);
        end

        // Randomized stream with random consumer backpressure.
        begin
            logic [31:0] expq[$];
            logic [31:0] cur_exp;
            logic [31:0] dsample;
            logic acc, del;
            int sent = 0, recv = 0, cyc = 0;
            while (recv < 32 && cyc < 4000) begin
                if (!in_valid && sent < 32 && $urandom_range(0, 3) != 0) begin
                    op = 2'($urandom); din = $urandom; shamt = 5'($urandom);
                    cur_exp = ref_shift(op, din, int'(shamt));
                    in_valid = 1'b1;
                end
                out_ready = 1'($urandom_range(0, 1));
                acc = in_valid && in_ready;
                del = out_valid && out_ready;
                dsample = dout;
                @(posedge clk); #1;
                cyc++;
                if (acc) begin
                    expq.push_back(cur_exp);
                    sent++;
                    in_valid = 1'b0;
                end
                if (del) begin
                    recv++;
                    if (expq.size() == 0) chk("stream_extra", dsample, 32'hFFFF_FFFF ^ dsample);
                    else chk($sformatf("stream%0d", recv), dsample, expq.pop_front());
                end
            end
            out_ready = 1'b0;
            in_valid = 1'b0;
            chk("stream_recv", 32'(recv), 32'd32);
            chk("stream_sent", 32'(sent), 32'd32);
            chk("stream_left", 32'(expq.size()), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
